// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD-to-binary converter slice:
//   - BCD_DIGIT_W   : width of one packed BCD digit
//   - BCD_MAX_NDIG  : largest digit count the word-check helper supports
//   - conv_state_e  : converter FSM states (IDLE, CONV, DONE)
//   - bcd_digit_invalid / bcd_word_invalid : out-of-range digit detection
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_DIGIT_W  = 4;
    localparam int BCD_MAX_NDIG = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // A digit is invalid when it encodes a value above nine.
    function automatic logic bcd_digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return (d > 4'd9);
    endfunction

    // ORs the per-digit check over the lowest ndig digits of a zero-extended word.
    function automatic logic bcd_word_invalid(
        input logic [BCD_DIGIT_W*BCD_MAX_NDIG-1:0] w,
        input int                                  ndig
    );
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_MAX_NDIG; i++) begin
            if (i < ndig) begin
                bad = bad | bcd_digit_invalid(w[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_rdd_step.sv
// -----------------------------------------------------------------------------
// bcd_rdd_step
// One iteration of reverse double-dabble, purely combinational.
// The concatenation {bcd, bin} is shifted right by one bit, so the BCD LSB
// enters the binary MSB. Every 4-bit digit of the shifted BCD part that is
// >= 8 then has 3 subtracted (digit-local, no borrow between digits).
//
// Ports:
//   bcd_i [4*NDIG-1:0] : BCD shift register before the step
//   bin_i [BW-1:0]     : binary shift register before the step
//   bcd_o [4*NDIG-1:0] : BCD shift register after shift and correction
//   bin_o [BW-1:0]     : binary shift register after shift
// -----------------------------------------------------------------------------
module bcd_rdd_step
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int BW   = 10
) (
    input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_i,
    input  logic [BW-1:0]               bin_i,
    output logic [BCD_DIGIT_W*NDIG-1:0] bcd_o,
    output logic [BW-1:0]               bin_o
);

    logic [BCD_DIGIT_W*NDIG-1:0] bcd_shift_s;

    // Shift {bcd, bin} right by one, then apply the per-digit minus-3 correction.
    always_comb begin
        bcd_shift_s = {1'b0, bcd_i[BCD_DIGIT_W*NDIG-1:1]};
        bin_o       = {bcd_i[0], bin_i[BW-1:1]};
        bcd_o       = bcd_shift_s;
        for (int i = 0; i < NDIG; i++) begin
            // A digit of 8 or more means a former tens-carry (worth 10) was
            // shifted in as 8; subtracting 3 restores the halved decimal value.
            if (bcd_shift_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd8) begin
                bcd_o[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    bcd_shift_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] - 4'd3;
            end else begin
                bcd_o[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    bcd_shift_s[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_converter
// Sequential packed-BCD to unsigned binary converter. A word is accepted in
// IDLE, converted with BW reverse double-dabble steps (one per enabled clock)
// in CONV, and presented in DONE until the sink takes it. Latency is fixed at
// BW enabled edges after the accept edge, including for invalid words.
//
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   ena       : global enable; when low, all state is frozen
//   in_valid  : source presents a BCD word
//   in_ready  : converter can accept a word (registered)
//   in_bcd    : packed BCD digits, digit 0 (units) in bits [3:0]
//   out_valid : result available (registered)
//   out_ready : sink accepts result
//   out_bin   : binary result, zero when the word had an invalid digit
//   out_err   : the word contained a digit greater than nine
// -----------------------------------------------------------------------------
module bcd_to_bin_converter
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int BW   = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_DIGIT_W*NDIG-1:0] in_bcd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BW-1:0]               out_bin,
    output logic                        out_err
);

    localparam int IW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(BW - 1);

    conv_state_e                        state_q;
    logic [BCD_DIGIT_W*NDIG-1:0]        bcd_sr_q;
    logic [BW-1:0]                      bin_sr_q;
    logic [IW-1:0]                      iter_q;
    logic                               err_q;
    logic                               in_ready_q;
    logic                               out_valid_q;
    logic [BW-1:0]                      out_bin_q;
    logic                               out_err_q;

    logic [BCD_DIGIT_W*NDIG-1:0]        bcd_sr_d;
    logic [BW-1:0]                      bin_sr_d;
    logic [BCD_DIGIT_W*BCD_MAX_NDIG-1:0] word_ext_s;
    logic                               word_bad_s;

    // Zero-extend the input word so the package helper can check it.
    always_comb begin
        word_ext_s                         = '0;
        word_ext_s[BCD_DIGIT_W*NDIG-1:0]   = in_bcd;
        word_bad_s                         = bcd_word_invalid(word_ext_s, NDIG);
    end

    bcd_rdd_step #(
        .NDIG (NDIG),
        .BW   (BW)
    ) u_step (
        .bcd_i (bcd_sr_q),
        .bin_i (bin_sr_q),
        .bcd_o (bcd_sr_d),
        .bin_o (bin_sr_d)
    );

    // Converter FSM with shift registers, iteration counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcd_sr_q    <= '0;
            bin_sr_q    <= '0;
            iter_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_sr_q   <= in_bcd;
                        bin_sr_q   <= '0;
                        iter_q     <= '0;
                        err_q      <= word_bad_s;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    bcd_sr_q <= bcd_sr_d;
                    bin_sr_q <= bin_sr_d;
                    iter_q   <= iter_q + IW'(1);
                    // The result is taken straight from the step output so
                    // out_valid rises on the BW-th step edge, not one later.
                    if (iter_q == ITER_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_bin_q   <= err_q ? '0 : bin_sr_d;
                        out_err_q   <= err_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_converter
// Self-checking bench for bcd_to_bin_converter (NDIG=3, BW=10). Expected
// values come from a decimal reference model (digit * power-of-ten sum).
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_converter;

    localparam int NDIG = 3;
    localparam int BW   = 10;
    localparam int LAT  = BW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             in_valid;
    logic             in_ready;
    logic [4*NDIG-1:0] in_bcd;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    out_bin;
    logic             out_err;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_to_bin_converter #(.NDIG(NDIG), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal value of the packed digits.
    function automatic int ref_value(input logic [4*NDIG-1:0] w);
        int v;
        int wt;
        v  = 0;
        wt = 1;
        for (int i = 0; i < NDIG; i++) begin
            v  = v + int'(w[i*4 +: 4]) * wt;
            wt = wt * 10;
        end
        return v;
    endfunction

    function automatic bit ref_err(input logic [4*NDIG-1:0] w);
        bit e;
        e = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (int'(w[i*4 +: 4]) > 9) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [BW-1:0] ref_bin(input logic [4*NDIG-1:0] w);
        if (ref_err(w)) return '0;
        return BW'(ref_value(w));
    endfunction

    function automatic logic [4*NDIG-1:0] to_bcd(input int n);
        logic [4*NDIG-1:0] w;
        int r;
        r = n;
        for (int i = 0; i < NDIG; i++) begin
            w[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return w;
    endfunction

    // Drive one word, wait for out_valid (bounded); leaves result un-handshaken.
    task automatic run_word(input logic [4*NDIG-1:0] w, output int lat,
                            output logic [BW-1:0] bin, output logic err);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = w;
        tick();
        in_valid  = 1'b0;
        in_bcd    = 12'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        bin = out_bin;
        err = out_err;
    endtask

    task automatic finish_word;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_bcd = 12'h000;
        tick();
        tick();
        n_checks++;
        if ({in_ready, out_valid, out_err} !== 3'b100 || out_bin !== 10'd0)
            $display("FAIL reset: rdy/vld/err=%b%b%b bin=%0d want 100 bin=0",
                     in_ready, out_valid, out_err, out_bin);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [4*NDIG-1:0] words[9];
        int lat; logic [BW-1:0] b; logic e;
        words[0] = 12'h000; words[1] = 12'h427; words[2] = 12'h999;
        for (int i = 3; i < 9; i++) words[i] = to_bcd($urandom_range(0, 999));
        foreach (words[i]) begin
            run_word(words[i], lat, b, e);
            n_checks++;
            if (lat !== LAT) $display("FAIL basic_latency %h: got %0d want %0d", words[i], lat, LAT);
            else n_pass++;
            n_checks++;
            if (b !== ref_bin(words[i]) || e !== 1'b0)
                $display("FAIL basic_value %h: got %0d err %b want %0d err 0", words[i], b, e, ref_bin(words[i]));
            else n_pass++;
            finish_word();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL basic_return_idle: rdy %b vld %b want 1 0", in_ready, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_invalid;
        logic [4*NDIG-1:0] words[6];
        int lat; logic [BW-1:0] b; logic e;
        words[0] = 12'h1A5; words[1] = 12'h105;
        for (int i = 2; i < 6; i++) words[i] = 12'($urandom);
        foreach (words[i]) begin
            run_word(words[i], lat, b, e);
            n_checks++;
            if (lat !== LAT) $display("FAIL invalid_latency %h: got %0d want %0d", words[i], lat, LAT);
            else n_pass++;
            n_checks++;
            if (b !== ref_bin(words[i]) || e !== ref_err(words[i]))
                $display("FAIL invalid_value %h: got %0d err %b want %0d err %b",
                         words[i], b, e, ref_bin(words[i]), ref_err(words[i]));
            else n_pass++;
            finish_word();
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [BW-1:0] b; logic e;
        run_word(12'h250, lat, b, e);
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_bin !== 10'd250 || in_ready !== 1'b0 || out_err !== 1'b0)
                $display("FAIL backpressure_hold: vld %b bin %0d rdy %b err %b want 1 250 0 0",
                         out_valid, out_bin, in_ready, out_err);
            else n_pass++;
        end
        finish_word();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release: vld %b rdy %b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_ena_gating;
        int lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = 12'h063;
        tick();
        in_valid  = 1'b0;
        in_bcd    = 12'h999;
        tick(); tick(); tick();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL ena_frozen_conv: vld %b rdy %b want 0 0", out_valid, in_ready);
            else n_pass++;
        end
        ena = 1'b1;
        lat = 7;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== LAT + 4 || out_bin !== 10'd63)
            $display("FAIL ena_latency: lat %0d bin %0d want %0d 63", lat, out_bin, LAT + 4);
        else n_pass++;
        // Handshake must be ignored while disabled.
        ena = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_bin !== 10'd63)
            $display("FAIL ena_frozen_done: vld %b bin %0d want 1 63", out_valid, out_bin);
        else n_pass++;
        ena = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL ena_resume: vld %b rdy %b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat; logic [BW-1:0] b; logic e;
        in_valid = 1'b1;
        in_bcd   = 12'h888;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_err} !== 3'b100 || out_bin !== 10'd0)
            $display("FAIL reset_mid: rdy/vld/err=%b%b%b bin=%0d want 100 bin=0",
                     in_ready, out_valid, out_err, out_bin);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        run_word(12'h012, lat, b, e);
        n_checks++;
        if (lat !== LAT || b !== 10'd12 || e !== 1'b0)
            $display("FAIL reset_mid_next: lat %0d bin %0d err %b want %0d 12 0", lat, b, e, LAT);
        else n_pass++;
        finish_word();
    endtask

    task automatic test_back_to_back;
        int rx;
        rx = 0;
        fork
            begin : driver
                bit acc;
                int guard;
                for (int n = 0; n < 1000; n++) begin
                    in_valid = 1'b1;
                    in_bcd   = to_bcd(n);
                    acc   = 1'b0;
                    guard = 0;
                    while (!acc && guard < 100) begin
                        acc = in_ready;
                        tick();
                        guard++;
                    end
                    if (!acc) begin
                        n_checks++;
                        $display("FAIL sweep_accept_timeout: word %0d got no accept want accept", n);
                        break;
                    end
                end
                in_valid = 1'b0;
            end
            begin : monitor
                bit hs;
                logic [BW-1:0] cb;
                logic ce;
                int cycles;
                cycles = 0;
                while (rx < 1000 && cycles < 60000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    hs = out_valid && out_ready;
                    cb = out_bin;
                    ce = out_err;
                    tick();
                    cycles++;
                    if (hs) begin
                        n_checks++;
                        if (cb !== BW'(rx) || ce !== 1'b0)
                            $display("FAIL sweep_result %0d: got %0d err %b want %0d err 0", rx, cb, ce, rx);
                        else n_pass++;
                        rx++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        n_checks++;
        if (rx !== 1000) $display("FAIL sweep_count: got %0d results want 1000", rx);
        else n_pass++;
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL sweep_no_extra: vld %b rdy %b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_backpressure();
        test_ena_gating();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_converter.md
Name: bcd_to_bin_converter

Overview:
- Sequential BCD-to-binary converter; consumes packed BCD digit words (e.g. units/tens/hundreds from the team's BCD counter) and returns the equivalent unsigned binary value.
- Uses iterative reverse double-dabble: one shift/correct step per clock, BW steps per conversion.
- Valid/ready on both sides; sits between BCD sources and binary datapath or compare logic in the TT design.

Parameters:
- NDIG, 3, number of BCD digits in the input word (digit 0 = units in bits [3:0]).
- BW, 10, binary output width; must satisfy 2^BW >= 10^NDIG; also equals the iteration count.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  global enable; when 0, all state frozen
- in_valid  input  1  source presents a BCD word
- in_ready  output  1  converter can accept a word
- in_bcd  input  4*NDIG  packed BCD digits, units in LSBs
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_bin  output  BW  binary result
- out_err  output  1  input contained a digit > 9

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, internal shift registers=0.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On an edge with ena & in_valid: load bcd_sr<=in_bcd, bin_sr<=0, iter<=0, err_r<=OR over digits of (digit>9); go to CONV.
- CONV: in_ready=0, out_valid=0. Each ena edge performs one step:
  - Shift the concatenation {bcd_sr, bin_sr} right by 1 (bcd_sr LSB enters bin_sr MSB).
  - Then, per 4-bit digit of the shifted bcd_sr, if digit>=8, subtract 3 (4-bit, no carry between digits).
  - iter increments. After step BW (iter==BW-1), go to DONE.
- DONE: out_valid=1; out_bin=bin_sr if err_r=0, else all zeros; out_err=err_r. Outputs held stable until ena & out_ready, then return to IDLE.
- Latency fixed: out_valid rises exactly BW enabled edges after the accept edge (10 for defaults), including the error case. There is no early-out.
- Throughput: one word per BW+2 enabled cycles. No accept occurs in DONE (in_ready=0), so no same-cycle overlap.
- out_valid never deasserts without a handshake. out_bin/out_err never change while out_valid=1.
- ena=0 in any state: no state, counter, or output change; handshakes are ignored.
- in_bcd is sampled only at the accept edge; later changes have no effect.
- Reset mid-CONV or mid-DONE: immediate return to reset values; the in-flight word is discarded.
- iter width: clog2(BW). Arithmetic is unsigned throughout.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4.
  - State enum {IDLE, CONV, DONE}.
  - Function bcd_digit_invalid(d) returning (d>4'd9).
  - Function bcd_word_invalid for NDIG digits.
- Sub-module bcd_rdd_step, purely combinational: one shift-right-plus-minus-3 iteration over {bcd, bin}, parameterised by NDIG and BW. The converter registers its output each CONV cycle; the sub-module can be unit-tested exhaustively.

Test Plan:
- Basic conversions, out_ready=1:
  - in_bcd=12'h000 -> out_bin=0, out_err=0, out_valid 10 cycles after accept.
  - 12'h427 -> out_bin=10'h1AB (427).
  - 12'h999 -> out_bin=999.
- Invalid digit: in_bcd=12'h1A5 -> out_valid after 10 cycles, out_err=1, out_bin=0. Next word 12'h105 -> 105, out_err=0.
- Backpressure: convert 12'h250, hold out_ready=0 for 7 cycles.
  - Required: out_valid=1 and out_bin=250 stable throughout; in_ready=0.
  - Release out_ready -> IDLE next cycle, in_ready=1.
- ena gating: deassert ena for 4 cycles mid-CONV on 12'h063 -> latency extends by exactly 4 cycles; result 63.
- Reset mid-operation: assert rst_n=0 at CONV step 5 of 12'h888 -> outputs immediately zero, in_ready=1. A new word 12'h012 then yields 12.
- Sweep: drive 000..999 in BCD order (counter-style source), back-to-back with random out_ready -> each out_bin equals its decimal index, no out_err, no lost or duplicated results.
